spi_wb_bridge_master: RTL and testbench
=======================================

# spi_wb_bridge_master

Wishbone-slave-controlled SPI master that issues 72-bit command frames to a remote SPI-to-Wishbone slave bridge and captures that bridge's response shift-out. It sits on the local Wishbone bus as a small register block. Software loads address, write data and command, then pulses GO. Each frame returns the data and error status of the remote's previous Wishbone transaction, so a remote read takes two frames.

## Interface
Parameters:
- CLK_DIV, 8: wb_clk_i cycles per SCLK half-period. Must be ≥ 6, since the remote debounces SCLK over 4 cycles.
- NCS_GAP, 16: wb_clk_i cycles NCS is held high after each frame.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone slave control.
- wbs_sel_i  in  4  byte selects; ignored, full-word access assumed.
- wbs_adr_i  in  32  only [3:2] decoded.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- ncs  out  1  SPI chip select, active-low.
- sclk  out  1  SPI clock, idle low.
- mosi  out  1  SPI data out.
- miso  in  1  SPI data in; asynchronous, double-flopped internally.

## Operation
- Registers, selected by wbs_adr_i[3:2]:
  - 0 CTRL.
    - Write: bit0 GO, bit1 WE, bits[7:4] SEL.
    - Read: bit0 BUSY, bit1 DONE, bit2 ERR, bit3 WE, bits[7:4] SEL.
  - 1 ADDR: R/W.
  - 2 WDATA: R/W.
  - 3 RDATA: read-only; writes are ignored.
- Writes to CTRL, ADDR and WDATA while BUSY=1 are acked but have no effect, including GO.
- A GO write while idle latches frame = {WE, 3'b000, SEL, ADDR, WDATA}, 72 bits, sent MSB first. It also clears DONE and sets BUSY.
- FSM states: IDLE → SETUP → HIGH ↔ LOW → GAP → IDLE.
  - SETUP, CLK_DIV cycles: ncs=0, sclk=0, mosi=frame[71].
  - HIGH, CLK_DIV cycles: sclk=1.
  - LOW, CLK_DIV cycles: sclk=0. mosi advances to the next bit on entry.
  - The 72nd HIGH is followed by a final LOW hold of CLK_DIV cycles. ncs then rises and the FSM enters GAP for NCS_GAP cycles.
  - GAP → IDLE: BUSY=0, DONE=1.
- A 7-bit bit counter runs 0..71. It increments on each HIGH→LOW transition. HIGH→LOW when the counter reads 71 leads to the hold, then GAP.
- miso (synchronised) is sampled in the last cycle of SETUP and of each LOW before a rising edge, 72 samples total. Samples shift into a 72-bit rx register, MSB first.
- At GAP entry: RDATA ← rx[31:0], ERR ← rx[71].
- Wishbone slave:
  - wbs_ack_o is asserted the cycle after cyc&stb and deasserted the following cycle.
  - Each access gets exactly one ack; there is no wait-state.
  - wbs_dat_o is registered and valid during ack.

## Timing
- Reset values: ncs=1, sclk=0, mosi=0, wbs_ack_o=0, wbs_dat_o=0. All registers, BUSY, DONE and ERR are 0. The FSM is in IDLE.
- BUSY rises the cycle after the GO ack.
- BUSY duration = CLK_DIV·(1 + 2·72) + NCS_GAP cycles, which is 1176 at the defaults.
- ncs falls on the same cycle BUSY rises.
- Reset mid-frame: on the next edge ncs=1, sclk=0, the FSM is in IDLE, and no partial RDATA update occurs.
- A GO write in the same cycle as GAP→IDLE is ignored, because BUSY is still 1 at the write. Software re-polls.
- The counter wraps are internal only; no frame exceeds 72 bits.

## Structure
- Shared package spi_wb_bridge_pkg holds:
  - FRAME_W = 72.
  - Field offsets: CMD_WE = 71, SEL = 67:64, ADDR = 63:32, DATA = 31:0, ERR = 71.
  - Register offsets: CTRL = 0, ADDR = 1, WDATA = 2, RDATA = 3.
  - FSM state encoding.
- One sub-module, spi_wb_bridge_master_clkgen: a half-period counter that emits a one-cycle phase-end strobe every CLK_DIV cycles while enabled.

## Test plan
- Remote write: ADDR=0x0000_1000, WDATA=0xDEADBEEF, CTRL=0x0F3 → mosi carries 0x8F_00001000_DEADBEEF, MSB first, over 72 rising edges. Then ncs high for 16 cycles, and DONE=1.
- Response capture: the miso model shifts 0x00_00000000_12345678 → RDATA=0x12345678, ERR=0.
- Error return: miso frame bit71=1 → CTRL read shows ERR=1; RDATA holds the low 32 bits.
- Busy lockout: write ADDR=0x55 mid-frame → ADDR readback is unchanged. A second GO mid-frame does not extend BUSY, which still lasts 1176 cycles.
- Reset at bit 40: assert wb_rst_i for one cycle → ncs=1 and sclk=0 on the next edge. All CSRs read 0. A new frame then runs cleanly.
- Edge timing: with CLK_DIV=6, every sclk half-period is exactly 6 cycles, and mosi is stable ≥ 6 cycles before each rising edge.

Source files
------------

// File: rtl/spi_wb_bridge_pkg.sv
// Shared constants, FSM encoding and frame builder for the SPI-to-Wishbone bridge master.
package spi_wb_bridge_pkg;

   localparam int FRAME_W    = 72;
   localparam int CMD_WE_BIT = 71;
   localparam int SEL_MSB    = 67;
   localparam int SEL_LSB    = 64;
   localparam int ADDR_MSB   = 63;
   localparam int ADDR_LSB   = 32;
   localparam int DATA_MSB   = 31;
   localparam int ERR_BIT    = 71;

   localparam logic [1:0] REG_CTRL  = 2'd0;
   localparam logic [1:0] REG_ADDR  = 2'd1;
   localparam logic [1:0] REG_WDATA = 2'd2;
   localparam logic [1:0] REG_RDATA = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_HIGH  = 3'd2,
      ST_LOW   = 3'd3,
      ST_GAP   = 3'd4
   } state_e;

   // Command frame layout: {WE, 3'b000, SEL, ADDR, WDATA}
   function automatic logic [FRAME_W-1:0] build_frame(input logic        we,
                                                      input logic [3:0]  sel,
                                                      input logic [31:0] adr,
                                                      input logic [31:0] dat);
      logic [FRAME_W-1:0] f;
      f                     = '0;
      f[CMD_WE_BIT]         = we;
      f[SEL_MSB:SEL_LSB]    = sel;
      f[ADDR_MSB:ADDR_LSB]  = adr;
      f[DATA_MSB:0]         = dat;
      return f;
   endfunction

endpackage

// File: rtl/spi_wb_bridge_master_clkgen.sv
// Half-period timer: one-cycle strobe at the end of every CLK_DIV-cycle phase while enabled.
module spi_wb_bridge_master_clkgen #(
   parameter int CLK_DIV = 8
) (
   input  logic clk_i,
   input  logic srst_i,
   input  logic en_i,
   output logic strobe_o
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt_q;

   // Count cycles within the current phase; restart from zero whenever disabled
   always_ff @(posedge clk_i) begin
      if (srst_i || !en_i) begin
         cnt_q <= '0;
      end else if (cnt_q == CW'(CLK_DIV - 1)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign strobe_o = en_i && (cnt_q == CW'(CLK_DIV - 1));

endmodule

// File: rtl/spi_wb_bridge_master.sv
// Wishbone register block driving a 72-bit SPI command/response frame to a remote bridge.
module spi_wb_bridge_master
   import spi_wb_bridge_pkg::*;
#(
   parameter int CLK_DIV = 8,
   parameter int NCS_GAP = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic [31:0] wbs_dat_o,
   output logic        wbs_ack_o,
   output logic        ncs,
   output logic        sclk,
   output logic        mosi,
   input  logic        miso
);

   localparam int GW = $clog2(NCS_GAP + 1);

   logic [1:0]         miso_sync_q;
   logic               ack_q;
   logic [31:0]        dat_q;
   logic               wr_pend_q;
   logic [1:0]         wr_reg_q;
   logic [31:0]        wr_dat_q;
   logic [31:0]        addr_q, wdata_q, rdata_q;
   logic               we_q, busy_q, done_q, err_q;
   logic [3:0]         sel_q;
   state_e             state_q;
   logic [FRAME_W-1:0] tx_q, rx_q;
   logic [6:0]         bit_q;
   logic               last_q;
   logic [GW-1:0]      gap_q;
   logic               ncs_q, sclk_q, mosi_q;
   logic               phase_end, clk_en, go;
   logic [31:0]        rd_data;
   logic [FRAME_W-1:0] go_frame;
   logic               unused_ok;

   assign unused_ok = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

   assign clk_en   = (state_q == ST_SETUP) || (state_q == ST_HIGH) || (state_q == ST_LOW);
   assign go       = wr_pend_q && (wr_reg_q == REG_CTRL) && wr_dat_q[0] && !busy_q;
   assign go_frame = build_frame(wr_dat_q[1], wr_dat_q[7:4], addr_q, wdata_q);

   spi_wb_bridge_master_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk_i    (wb_clk_i),
      .srst_i   (wb_rst_i),
      .en_i     (clk_en),
      .strobe_o (phase_end)
   );

   // Register read multiplexer
   always_comb begin
      rd_data = '0;
      case (wbs_adr_i[3:2])
         REG_CTRL:  rd_data = {24'd0, sel_q, we_q, err_q, done_q, busy_q};
         REG_ADDR:  rd_data = addr_q;
         REG_WDATA: rd_data = wdata_q;
         REG_RDATA: rd_data = rdata_q;
         default:   rd_data = '0;
      endcase
   end

   // Wishbone handshake: one-cycle ack, registered read data, write committed after ack
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         miso_sync_q <= '0;
         ack_q       <= 1'b0;
         dat_q       <= '0;
         wr_pend_q   <= 1'b0;
         wr_reg_q    <= '0;
         wr_dat_q    <= '0;
      end else begin
         miso_sync_q <= {miso_sync_q[0], miso};
         ack_q       <= wbs_cyc_i && wbs_stb_i && !ack_q;
         wr_pend_q   <= wbs_cyc_i && wbs_stb_i && wbs_we_i && !ack_q;
         wr_reg_q    <= wbs_adr_i[3:2];
         wr_dat_q    <= wbs_dat_i;
         if (wbs_cyc_i && wbs_stb_i && !ack_q) begin
            dat_q <= rd_data;
         end
      end
   end

   // CSR updates plus the frame sequencer with registered SPI outputs
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         state_q <= ST_IDLE;
         tx_q    <= '0;
         rx_q    <= '0;
         bit_q   <= '0;
         last_q  <= 1'b0;
         gap_q   <= '0;
         ncs_q   <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
      end else begin
         // Software writes only land while no frame is in flight
         if (wr_pend_q && !busy_q) begin
            case (wr_reg_q)
               REG_CTRL: begin
                  we_q  <= wr_dat_q[1];
                  sel_q <= wr_dat_q[7:4];
               end
               REG_ADDR:  addr_q  <= wr_dat_q;
               REG_WDATA: wdata_q <= wr_dat_q;
               default: ;
            endcase
         end

         case (state_q)
            ST_IDLE: begin
               if (go) begin
                  tx_q    <= go_frame;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  ncs_q   <= 1'b0;
                  sclk_q  <= 1'b0;
                  mosi_q  <= go_frame[CMD_WE_BIT];
                  bit_q   <= '0;
                  last_q  <= 1'b0;
                  state_q <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (phase_end) begin
                  rx_q    <= {rx_q[FRAME_W-2:0], miso_sync_q[1]};
                  sclk_q  <= 1'b1;
                  state_q <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (phase_end) begin
                  sclk_q  <= 1'b0;
                  tx_q    <= tx_q << 1;
                  mosi_q  <= tx_q[FRAME_W-2];
                  state_q <= ST_LOW;
                  if (bit_q == 7'd71) begin
                     last_q <= 1'b1;
                     bit_q  <= '0;
                  end else begin
                     bit_q  <= bit_q + 7'd1;
                  end
               end
            end
            ST_LOW: begin
               if (phase_end) begin
                  if (last_q) begin
                     // Final hold done: release chip select and publish the response
                     ncs_q   <= 1'b1;
                     rdata_q <= rx_q[DATA_MSB:0];
                     err_q   <= rx_q[ERR_BIT];
                     gap_q   <= '0;
                     state_q <= ST_GAP;
                  end else begin
                     rx_q    <= {rx_q[FRAME_W-2:0], miso_sync_q[1]};
                     sclk_q  <= 1'b1;
                     state_q <= ST_HIGH;
                  end
               end
            end
            ST_GAP: begin
               if (gap_q == GW'(NCS_GAP - 1)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign ncs       = ncs_q;
   assign sclk      = sclk_q;
   assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_wb_bridge_master.sv
// Bench for spi_wb_bridge_master: CSR vector table, frame scoreboard, SPI timing corners.
module tb_spi_wb_bridge_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc0 = 1'b0, cyc1 = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'hF;
   logic [31:0] adr = '0, dw = '0;
   logic [31:0] dr0, dr1;
   logic        ack0, ack1;
   logic        ncs0, sclk0, mosi0, ncs1, sclk1, mosi1;
   logic        miso0 = 1'b0;
   logic        miso1 = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   spi_wb_bridge_master #(.CLK_DIV(8), .NCS_GAP(16)) dut0 (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc0), .wbs_stb_i(stb), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dw), .wbs_dat_o(dr0), .wbs_ack_o(ack0),
      .ncs(ncs0), .sclk(sclk0), .mosi(mosi0), .miso(miso0));

   spi_wb_bridge_master #(.CLK_DIV(6), .NCS_GAP(16)) dut1 (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc1), .wbs_stb_i(stb), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dw), .wbs_dat_o(dr1), .wbs_ack_o(ack1),
      .ncs(ncs1), .sclk(sclk1), .mosi(mosi1), .miso(miso1));

   task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   // Caller is 1 time unit after a rising edge; returns 1 unit after the ack edge
   task automatic wb(input int dev, input bit wr, input logic [1:0] rg,
                     input logic [31:0] d, output logic [31:0] q);
      bit got;
      got = 1'b0;
      q   = '0;
      if (dev == 0) cyc0 = 1'b1; else cyc1 = 1'b1;
      stb = 1'b1; we = wr; adr = {28'd0, rg, 2'b00}; dw = d;
      for (int i = 0; i < 4 && !got; i++) begin
         @(posedge clk); #1;
         if (((dev == 0) ? ack0 : ack1) === 1'b1) begin
            got = 1'b1;
            q   = (dev == 0) ? dr0 : dr1;
         end
      end
      cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0; we = 1'b0;
      if (!got) begin
         total++; bad++;
         $display("FAIL wb_ack_timeout: got=no_ack want=ack reg=%0d", rg);
      end
   endtask

   task automatic wr(input int dev, input logic [1:0] rg, input logic [31:0] d);
      logic [31:0] q;
      wb(dev, 1'b1, rg, d, q);
   endtask

   task automatic rd_chk(input int dev, input logic [1:0] rg, input logic [31:0] exp, input string name);
      logic [31:0] q;
      wb(dev, 1'b0, rg, 32'd0, q);
      check(name, 72'(q), 72'(exp));
   endtask

   // Waits for ncs to go low and back high; returns 1 unit after the rising edge that raised ncs
   task automatic wait_rise(input int dev, input int limit);
      bit low_seen, done;
      logic n;
      low_seen = 1'b0; done = 1'b0;
      for (int i = 0; i < limit && !done; i++) begin
         @(posedge clk); #1;
         n = (dev == 0) ? ncs0 : ncs1;
         if (n === 1'b0) low_seen = 1'b1;
         else if (low_seen) done = 1'b1;
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL ncs_rise_timeout: got=timeout want=rise dev=%0d", dev);
      end
   endtask

   // ---------------- dev0 scoreboard: remote-bridge model and mosi capture ----------------
   logic [71:0] exp0_q[$];
   logic [71:0] exp1_q[$];
   logic [71:0] resp0 = '0;
   logic [71:0] sh0 = '0, cap0 = '0;
   logic        pn0 = 1'b1, ps0 = 1'b0, act0 = 1'b0, abort0 = 1'b0;
   int          nb0 = 0, low0 = 0;

   always @(negedge clk) begin
      if (ncs0 === 1'b0 && pn0 === 1'b1) begin
         sh0 = resp0; miso0 = sh0[71];
         nb0 = 0; low0 = 1; cap0 = '0; act0 = 1'b1; ps0 = sclk0;
      end else if (ncs0 === 1'b0) begin
         low0++;
         if (sclk0 === 1'b1 && ps0 === 1'b0) begin
            cap0 = {cap0[70:0], mosi0};
            nb0++;
         end
         if (sclk0 === 1'b0 && ps0 === 1'b1) begin
            sh0 = sh0 << 1; miso0 = sh0[71];
         end
         ps0 = sclk0;
      end else if (ncs0 === 1'b1 && pn0 === 1'b0 && act0) begin
         act0 = 1'b0;
         if (!abort0) begin
            check("rising_edges0", 72'(nb0), 72'd72);
            check("ncs_low_cycles0", 72'(low0), 72'd1160);
            if (exp0_q.size() == 0) begin
               total++; bad++;
               $display("FAIL mosi_frame0: got=%h want=no_frame", cap0);
            end else begin
               check("mosi_frame0", cap0, exp0_q.pop_front());
            end
         end
      end
      pn0 = ncs0;
   end

   // ---------------- dev1 (CLK_DIV=6): half-period and mosi setup checks ----------------
   logic [71:0] cap1 = '0;
   logic        pn1 = 1'b1, ps1 = 1'b0, pm1 = 1'b0, act1 = 1'b0;
   int          nb1 = 0, low1 = 0, run_s1 = 0, run_m1 = 0, vhp1 = 0, vsu1 = 0;

   always @(negedge clk) begin
      if (ncs1 === 1'b0 && pn1 === 1'b1) begin
         run_s1 = 1; run_m1 = 1; ps1 = sclk1; pm1 = mosi1;
         nb1 = 0; low1 = 1; cap1 = '0; act1 = 1'b1;
      end else if (ncs1 === 1'b0) begin
         low1++;
         if (sclk1 !== ps1) begin
            if (run_s1 != 6) vhp1++;
            run_s1 = 1;
            if (sclk1 === 1'b1) begin
               if (run_m1 < 6) vsu1++;
               cap1 = {cap1[70:0], mosi1};
               nb1++;
            end
         end else begin
            run_s1++;
         end
         if (mosi1 !== pm1) run_m1 = 1; else run_m1++;
         ps1 = sclk1; pm1 = mosi1;
      end else if (ncs1 === 1'b1 && pn1 === 1'b0 && act1) begin
         act1 = 1'b0;
         if (run_s1 != 6) vhp1++;
         check("rising_edges1", 72'(nb1), 72'd72);
         check("ncs_low_cycles1", 72'(low1), 72'd870);
         check("half_period_violations", 72'(vhp1), 72'd0);
         check("mosi_setup_violations", 72'(vsu1), 72'd0);
         if (exp1_q.size() == 0) begin
            total++; bad++;
            $display("FAIL mosi_frame1: got=%h want=no_frame", cap1);
         end else begin
            check("mosi_frame1", cap1, exp1_q.pop_front());
         end
      end
      pn1 = ncs1;
   end

   // ---------------- CSR vector table ----------------
   typedef struct {
      bit          wr;
      logic [1:0]  rg;
      logic [31:0] data;   // write data, or expected read data
   } vec_t;

   vec_t vecs[14];

   initial begin
      int lowc;
      vecs[0]  = '{1'b0, 2'd0, 32'h0000_0000};
      vecs[1]  = '{1'b0, 2'd1, 32'h0000_0000};
      vecs[2]  = '{1'b0, 2'd2, 32'h0000_0000};
      vecs[3]  = '{1'b0, 2'd3, 32'h0000_0000};
      vecs[4]  = '{1'b1, 2'd1, 32'hA5A5_0001};
      vecs[5]  = '{1'b0, 2'd1, 32'hA5A5_0001};
      vecs[6]  = '{1'b1, 2'd2, 32'h1234_0000};
      vecs[7]  = '{1'b0, 2'd2, 32'h1234_0000};
      vecs[8]  = '{1'b1, 2'd3, 32'hFFFF_FFFF};
      vecs[9]  = '{1'b0, 2'd3, 32'h0000_0000};
      vecs[10] = '{1'b1, 2'd0, 32'h0000_00A2};
      vecs[11] = '{1'b0, 2'd0, 32'h0000_00A8};
      vecs[12] = '{1'b1, 2'd0, 32'h0000_0000};
      vecs[13] = '{1'b0, 2'd0, 32'h0000_0000};

      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ncs", 72'(ncs0), 72'd1);
      check("reset_sclk", 72'(sclk0), 72'd0);
      check("reset_mosi", 72'(mosi0), 72'd0);
      check("reset_ack", 72'(ack0), 72'd0);
      check("reset_dat_o", 72'(dr0), 72'd0);
      check("reset_ncs1", 72'(ncs1), 72'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         logic [31:0] q;
         wb(0, vecs[i].wr, vecs[i].rg, vecs[i].data, q);
         if (!vecs[i].wr) check($sformatf("csr_vec%0d", i), 72'(q), 72'(vecs[i].data));
         $display("vec %0d: %s reg=%0d data=%h", i, vecs[i].wr ? "wr" : "rd", vecs[i].rg, q);
         @(posedge clk); #1;
         check($sformatf("ack_pulse%0d", i), 72'(ack0), 72'd0);
      end

      // Frame A: remote write, response capture, exact gap length (BUSY still 1 at gap cycle 16)
      wr(0, 2'd1, 32'h0000_1000);
      wr(0, 2'd2, 32'hDEAD_BEEF);
      resp0 = 72'h00_00000000_12345678;
      exp0_q.push_back(72'h8F_00001000_DEADBEEF);
      wr(0, 2'd0, 32'h0000_00F3);
      wait_rise(0, 3000);
      repeat (15) @(posedge clk);
      #1;
      rd_chk(0, 2'd0, 32'h0000_00F9, "ctrl_busy_late_gap");
      rd_chk(0, 2'd0, 32'h0000_00FA, "ctrl_done_a");
      rd_chk(0, 2'd3, 32'h1234_5678, "rdata_a");
      $display("frame A: write frame sent, response captured");

      // Frame B: error return, writes and GO locked out while busy
      wr(0, 2'd1, 32'h0000_2000);
      wr(0, 2'd2, 32'h0BAD_F00D);
      resp0 = 72'h80_00000000_CAFE0001;
      exp0_q.push_back(72'h03_00002000_0BADF00D);
      wr(0, 2'd0, 32'h0000_0031);
      repeat (8 * 81) @(posedge clk);
      #1;
      wr(0, 2'd1, 32'h0000_0055);
      wr(0, 2'd0, 32'h0000_00F3);
      rd_chk(0, 2'd1, 32'h0000_2000, "addr_locked");
      rd_chk(0, 2'd2, 32'h0BAD_F00D, "wdata_locked");
      wait_rise(0, 3000);
      repeat (16) @(posedge clk);
      #1;
      rd_chk(0, 2'd0, 32'h0000_0036, "ctrl_err_idle");
      rd_chk(0, 2'd3, 32'hCAFE_0001, "rdata_err");
      $display("frame B: error frame, lockout checked");

      // Frame C: reset at about bit 40
      wr(0, 2'd1, 32'h0000_3000);
      wr(0, 2'd0, 32'h0000_0001);
      abort0 = 1'b1;
      repeat (8 + 40 * 16) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midreset_ncs", 72'(ncs0), 72'd1);
      check("midreset_sclk", 72'(sclk0), 72'd0);
      rd_chk(0, 2'd0, 32'h0, "midreset_ctrl");
      rd_chk(0, 2'd1, 32'h0, "midreset_addr");
      rd_chk(0, 2'd2, 32'h0, "midreset_wdata");
      rd_chk(0, 2'd3, 32'h0, "midreset_rdata");
      repeat (4) @(posedge clk);
      #1;
      abort0 = 1'b0;
      $display("frame C: aborted by reset");

      // Frame D: clean frame after reset; GO committed on the GAP->IDLE edge is ignored
      wr(0, 2'd1, 32'hABCD_0000);
      wr(0, 2'd2, 32'h0000_0001);
      resp0 = 72'h00_FFFFFFFF_87654321;
      exp0_q.push_back(72'h85_ABCD0000_00000001);
      wr(0, 2'd0, 32'h0000_0053);
      wait_rise(0, 3000);
      repeat (14) @(posedge clk);
      #1;
      wr(0, 2'd0, 32'h0000_00F3);
      rd_chk(0, 2'd0, 32'h0000_005A, "ctrl_after_late_go");
      rd_chk(0, 2'd3, 32'h8765_4321, "rdata_d");
      lowc = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (ncs0 !== 1'b1) lowc++;
      end
      check("late_go_ignored", 72'(lowc), 72'd0);
      $display("frame D: clean frame after reset, late GO ignored");

      // Frame E: CLK_DIV=6 instance, edge timing
      wr(1, 2'd1, 32'h0F0F_0F0F);
      wr(1, 2'd2, 32'h3C3C_3C3C);
      exp1_q.push_back(72'h8E_0F0F0F0F_3C3C3C3C);
      wr(1, 2'd0, 32'h0000_00E3);
      wait_rise(1, 3000);
      repeat (20) @(posedge clk);
      #1;
      rd_chk(1, 2'd0, 32'h0000_00EA, "ctrl_done_div6");
      check("scoreboard_drained", 72'(exp0_q.size() + exp1_q.size()), 72'd0);
      $display("frame E: CLK_DIV=6 edge timing");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
